// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register and divider sequencing controller.
// Optional divide-by-zero early trap is enabled by defining DIV_ZERO_TRAP_EN.
module hilo_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  output logic        div_resetlocal,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    exc_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Architectural writes and a new start may coincide; both are honoured.
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
        if (op_start) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
`ifdef DIV_ZERO_TRAP_EN
        if (cnt_q == 5'd0 && div_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
          exc_d   = 1'b1;
        end else if (cnt_q == 5'd31) begin
          state_d = CAPT;
        end
`else
        if (cnt_q == 5'd31) state_d = CAPT;
`endif
      end
      CAPT: begin
        hi_d    = div_hi;
        lo_d    = div_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef DIV_ZERO_TRAP_EN
  logic unused_div_zero;
  assign unused_div_zero = div_zero;
`endif

  assign div_resetlocal = (state_q == LOAD);
  assign div_dividend   = a_q;
  assign div_divisor    = b_q;
  assign hi             = hi_q;
  assign lo             = lo_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign div_zero_exc   = exc_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - Self-checking bench for hilo_ctrl with a behavioural divider.
module tb_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start;
  logic [31:0] op_a, op_b;
  logic        mthi_we, mtlo_we;
  logic [31:0] wdata;
  logic        div_resetlocal;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_hi, div_lo;
  logic        div_zero;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero_exc;

  int checks = 0;
  int failures = 0;

  hilo_ctrl dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_a(op_a), .op_b(op_b),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .div_resetlocal(div_resetlocal), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_hi(div_hi), .div_lo(div_lo), .div_zero(div_zero),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero_exc(div_zero_exc)
  );

  always #5 clk = ~clk;

  // Divider stand-in: remainder on div_hi, quotient on div_lo, 0/0 for a zero divisor.
  always_comb begin
    div_zero = (div_divisor == 32'd0);
    div_hi   = div_zero ? 32'd0 : div_dividend % div_divisor;
    div_lo   = div_zero ? 32'd0 : div_dividend / div_divisor;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Issues op_start for one edge (E0), then watches a fixed window of edges.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int window,
                        output int lat, output int ndone, output int nexc, output bit held);
    op_a = a; op_b = b; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    lat = -1; ndone = 0; nexc = 0; held = 1'b1;
    for (int i = 1; i <= window; i++) begin
      if (busy && (div_dividend !== a || div_divisor !== b)) held = 1'b0;
      tick();
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (div_zero_exc) nexc++;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    int          exc;
  } vec_t;

  vec_t vecs[4];
  int lat, ndone, nexc;
  bit held;

  initial begin
    vecs[0] = '{32'd100, 32'd7, 34, 32'd2, 32'd14, 0};
`ifdef DIV_ZERO_TRAP_EN
    vecs[1] = '{32'd5, 32'd0, 2, 32'd2, 32'd14, 1};
`else
    vecs[1] = '{32'd5, 32'd0, 34, 32'd0, 32'd0, 0};
`endif
    vecs[2] = '{32'hFFFF_FFFF, 32'd1, 34, 32'd0, 32'hFFFF_FFFF, 0};
    vecs[3] = '{32'd7, 32'd100, 34, 32'd7, 32'd0, 0};

    reset = 1'b1; op_start = 1'b0; op_a = 32'h1111_1111; op_b = 32'h2222_2222;
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hFFFF_FFFF;
    tick(); tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_exc", {31'd0, div_zero_exc}, 32'd0);
    chk("rst_resetlocal", {31'd0, div_resetlocal}, 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    chk("rst_divisor", div_divisor, 32'd0);

    // First division: also check the load strobe and busy right after E0.
    op_a = 32'd100; op_b = 32'd7; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    chk("e0_busy", {31'd0, busy}, 32'd1);
    chk("e0_resetlocal", {31'd0, div_resetlocal}, 32'd1);
    tick();
    chk("e1_resetlocal", {31'd0, div_resetlocal}, 32'd0);
    for (int i = 0; i < 40; i++) tick();

    for (int v = 0; v < 4; v++) begin
      run_op(vecs[v].a, vecs[v].b, 45, lat, ndone, nexc, held);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_done_count", v), ndone, 32'd1);
      chk($sformatf("v%0d_exc_count", v), nexc, vecs[v].exc);
      chk($sformatf("v%0d_hi", v), hi, vecs[v].hi);
      chk($sformatf("v%0d_lo", v), lo, vecs[v].lo);
      chk($sformatf("v%0d_operands_held", v), {31'd0, held}, 32'd1);
    end

    // Architectural writes in IDLE.
    mthi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    mtlo_we = 1'b0;
    chk("mthi_idle", hi, 32'hDEAD_BEEF);
    chk("mtlo_idle", lo, 32'h1234_5678);

    // Writes while busy are dropped.
    op_a = 32'd100; op_b = 32'd7; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    tick(); tick();
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h5555_AAAA;
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    chk("mthi_busy", hi, 32'hDEAD_BEEF);
    chk("mtlo_busy", lo, 32'h1234_5678);
    for (int i = 0; i < 40; i++) tick();
    chk("after_busy_hi", hi, 32'd2);
    chk("after_busy_lo", lo, 32'd14);

    // Second op_start at E10 is ignored.
    op_a = 32'd50; op_b = 32'd5; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    ndone = 0; held = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      if (i == 10) begin op_a = 32'd9; op_b = 32'd3; op_start = 1'b1; end
      else op_start = 1'b0;
      if (busy && div_divisor !== 32'd5) held = 1'b0;
      tick();
      if (done) ndone++;
    end
    op_start = 1'b0;
    chk("restart_done_count", ndone, 32'd1);
    chk("restart_lo", lo, 32'd10);
    chk("restart_hi", hi, 32'd0);
    chk("restart_operands_held", {31'd0, held}, 32'd1);

    // op_start with mthi_we in the same cycle: write lands, capture overwrites it.
    op_a = 32'd9; op_b = 32'd3; op_start = 1'b1; mthi_we = 1'b1; wdata = 32'h0000_AAAA;
    tick();
    op_start = 1'b0; mthi_we = 1'b0;
    chk("same_cycle_hi_write", hi, 32'h0000_AAAA);
    for (int i = 0; i < 40; i++) tick();
    chk("same_cycle_hi_capt", hi, 32'd0);
    chk("same_cycle_lo_capt", lo, 32'd3);

    // Reset at E10 aborts without a done pulse.
    op_a = 32'd100; op_b = 32'd7; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 32'd0);
    chk("abort_lo_after", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
